// File: rtl/pc_w_display_pkg.sv
// Shared constants for the pc/w seven-segment display: active-low segment codes,
// anode idle pattern and the digit index type.
package display_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef logic [1:0] digit_t;

    localparam digit_t DIGIT_LAST = 2'd3;
    // Digit 2 is the low pc nibble; its decimal point separates pc from w.
    localparam digit_t DIGIT_DP   = 2'd2;

endpackage

// File: rtl/pc_w_display_if.sv
// Bus between the micro core state taps and the display driver. Plain sampled
// signals, no handshake: the display snapshots pc/w on its own schedule.
interface pc_w_display_if;

    logic [7:0] pc;
    logic [7:0] w;
    logic       hold;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output pc,
        output w,
        output hold,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  pc,
        input  w,
        input  hold,
        output an,
        output seg,
        output dp
    );

endinterface

// File: rtl/pc_w_display_hex_to_7seg.sv
// Combinational nibble to active-low seven-segment lookup.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/pc_w_display.sv
// Snapshots pc and w from the micro core and scans them in hex onto a 4-digit
// common-anode display: pc on the left pair, w on the right pair.
module pc_w_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    pc_w_display_if.slave      bus
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt;
    digit_t        digit;
    logic [7:0]    pc_s;
    logic [7:0]    w_s;
    logic          load_pending;

    logic          cnt_last;
    logic          do_load;
    logic          blank;
    logic [3:0]    nib;
    logic [6:0]    seg_c;

    assign cnt_last = (cnt == CW'(REFRESH_DIV - 1));
    // Reloading only on the wrap into digit 0 keeps every scan coherent.
    assign do_load  = load_pending || (cnt_last && (digit == DIGIT_LAST) && !bus.hold);
    assign blank    = (int'(cnt) < BLANK_CYCLES);

    always_comb begin
        nib = 4'h0;
        case (digit)
            2'd0: nib = w_s[3:0];
            2'd1: nib = w_s[7:4];
            2'd2: nib = pc_s[3:0];
            2'd3: nib = pc_s[7:4];
            default: nib = 4'h0;
        endcase
    end

    hex_to_7seg u_hex (
        .nib (nib),
        .seg (seg_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            digit        <= '0;
            pc_s         <= '0;
            w_s          <= '0;
            load_pending <= 1'b1;
            bus.an       <= AN_OFF;
            bus.seg      <= SEG_BLANK;
            bus.dp       <= 1'b1;
        end else begin
            if (cnt_last) begin
                cnt   <= '0;
                digit <= digit + 2'd1;
            end else begin
                cnt   <= cnt + 1'b1;
            end

            if (do_load) begin
                pc_s         <= bus.pc;
                w_s          <= bus.w;
                load_pending <= 1'b0;
            end

            // Outputs are built from this cycle's state, so they lag it by one edge.
            if (blank) begin
                bus.an  <= AN_OFF;
                bus.seg <= SEG_BLANK;
                bus.dp  <= 1'b1;
            end else begin
                bus.an  <= ~(4'b0001 << digit);
                bus.seg <= seg_c;
                bus.dp  <= (digit != DIGIT_DP);
            end
        end
    end

endmodule
